// File: rtl/md_unit.sv
// Purpose : multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO pair; also executes MTHI/MTLO.
// Latency : HI/LO update MULT_CYCLES (mult) or DIV_CYCLES (div) edges after accept; MTHI/MTLO on the accepting edge.
// Backpres: no queueing; start while busy is dropped, so the hazard unit must stall on busy | (start & op<=3).
//
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous, active-high; clears all state
//   start   - request valid this cycle
//   op      - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   inputA  - rs operand / dividend / MTHI-MTLO source
//   inputB  - rt operand / divisor
//   busy    - registered; high for exactly N cycles after an accepted mult/div
//   hi, lo  - architectural HI/LO registers
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] inputA,
  input  logic [31:0] inputB,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          busy_nxt;
  logic [31:0]   hi_nxt, lo_nxt;
  logic [31:0]   res_hi, res_hi_nxt;
  logic [31:0]   res_lo, res_lo_nxt;
  // Cleared for a zero divisor so the completion edge leaves HI/LO untouched.
  logic          res_upd, res_upd_nxt;

  // ---------------------------------------------------------------------------
  // Multiply: sign- or zero-extend both operands to 33 bits so one signed
  // multiplier serves MULT and MULTU; the low 64 bits are the exact product.
  // ---------------------------------------------------------------------------
  logic               mul_signed;
  logic signed [32:0] mul_a, mul_b;
  logic signed [65:0] mul_prod;

  assign mul_signed = (op == OP_MULT);
  assign mul_a      = {mul_signed & inputA[31], inputA};
  assign mul_b      = {mul_signed & inputB[31], inputB};
  assign mul_prod   = mul_a * mul_b;

  // ---------------------------------------------------------------------------
  // Divide: done on magnitudes with an unsigned divider, then signs restored.
  // Quotient is negative when operand signs differ (truncation toward zero),
  // remainder takes the dividend's sign. 0x80000000 / -1 falls out naturally:
  // magnitude 0x80000000 / 1, signs equal, so the quotient wraps to 0x80000000.
  // ---------------------------------------------------------------------------
  logic        div_signed;
  logic        div_a_neg, div_b_neg;
  logic [31:0] div_a_mag, div_b_mag, div_b_safe;
  logic [31:0] div_q_mag, div_r_mag;
  logic [31:0] div_q, div_r;
  logic        div_by_zero;

  assign div_signed  = (op == OP_DIV);
  assign div_a_neg   = div_signed & inputA[31];
  assign div_b_neg   = div_signed & inputB[31];
  assign div_a_mag   = div_a_neg ? (~inputA + 32'd1) : inputA;
  assign div_b_mag   = div_b_neg ? (~inputB + 32'd1) : inputB;
  assign div_by_zero = (inputB == 32'd0);
  // Keep the divider free of X on a zero divisor; that result is never committed.
  assign div_b_safe  = div_by_zero ? 32'd1 : div_b_mag;
  assign div_q_mag   = div_a_mag / div_b_safe;
  assign div_r_mag   = div_a_mag % div_b_safe;
  assign div_q       = (div_a_neg ^ div_b_neg) ? (~div_q_mag + 32'd1) : div_q_mag;
  assign div_r       = div_a_neg ? (~div_r_mag + 32'd1) : div_r_mag;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      res_hi  <= 32'd0;
      res_lo  <= 32'd0;
      res_upd <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      busy    <= busy_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
      res_hi  <= res_hi_nxt;
      res_lo  <= res_lo_nxt;
      res_upd <= res_upd_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    busy_nxt    = busy;
    hi_nxt      = hi;
    lo_nxt      = lo;
    res_hi_nxt  = res_hi;
    res_lo_nxt  = res_lo;
    res_upd_nxt = res_upd;

    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              res_hi_nxt  = mul_prod[63:32];
              res_lo_nxt  = mul_prod[31:0];
              res_upd_nxt = 1'b1;
              cnt_nxt     = CW'(MULT_CYCLES);
              busy_nxt    = 1'b1;
              state_nxt   = BUSY;
            end
            OP_DIV, OP_DIVU: begin
              res_hi_nxt  = div_r;
              res_lo_nxt  = div_q;
              res_upd_nxt = ~div_by_zero;
              cnt_nxt     = CW'(DIV_CYCLES);
              busy_nxt    = 1'b1;
              state_nxt   = BUSY;
            end
            OP_MTHI: hi_nxt = inputA;
            OP_MTLO: lo_nxt = inputA;
            default: ;
          endcase
        end
      end

      BUSY: begin
        // Any start seen here is a protocol violation and is simply dropped.
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          if (res_upd) begin
            hi_nxt = res_hi;
            lo_nxt = res_lo;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] inputA;
  logic [31:0] inputB;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .inputA(inputA),
    .inputB(inputB),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the request is accepted on the following posedge and
  // the task returns at the negedge just after that accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    inputA = a;
    inputB = b;
    @(negedge clk);
    start  = 1'b0;
    op     = 3'd7;
    inputA = 32'd0;
    inputB = 32'd0;
  endtask

  // Counts busy cycles from the negedge after the accepting edge, and checks
  // HI/LO hold still while busy. Bounded so a stuck busy cannot hang the run.
  task automatic wait_done(input string tag, input int n);
    int          cyc;
    logic [31:0] h0, l0;
    logic        moved;
    cyc   = 0;
    h0    = hi;
    l0    = lo;
    moved = 1'b0;
    while (busy && cyc < 200) begin
      if (hi !== h0 || lo !== l0) moved = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check({tag, " busy_cycles"}, 32'(cyc), 32'(n));
    check({tag, " hold"}, {31'd0, moved}, 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    op     = 3'd7;
    inputA = 32'd0;
    inputB = 32'd0;

    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // MULT -3 * 5 = -15
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    check("mult busy rise", {31'd0, busy}, 32'd1);
    wait_done("mult", 5);
    check("mult hi", hi, 32'hFFFF_FFFF);
    check("mult lo", lo, 32'hFFFF_FFF1);

    // MULTU 0xFFFFFFFF * 2, then DIVU 7/2 the cycle busy drops
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_done("multu", 5);
    check("multu hi", hi, 32'h0000_0001);
    check("multu lo", lo, 32'hFFFF_FFFE);
    issue(3'd3, 32'd7, 32'd2);
    check("divu b2b busy", {31'd0, busy}, 32'd1);
    wait_done("divu", 10);
    check("divu hi", hi, 32'd1);
    check("divu lo", lo, 32'd3);

    // DIV -7 / 2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div neg", 10);
    check("div neg hi", hi, 32'hFFFF_FFFF);
    check("div neg lo", lo, 32'hFFFF_FFFD);

    // DIV overflow case wraps
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div ovf", 10);
    check("div ovf hi", hi, 32'd0);
    check("div ovf lo", lo, 32'h8000_0000);

    // MTHI in IDLE
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    check("mthi hi", hi, 32'hDEAD_BEEF);
    check("mthi busy", {31'd0, busy}, 32'd0);
    check("mthi lo kept", lo, 32'h8000_0000);

    // Divide by zero keeps HI/LO
    issue(3'd4, 32'h11, 32'd0);
    issue(3'd5, 32'h22, 32'd0);
    check("mtlo lo", lo, 32'h22);
    issue(3'd3, 32'd7, 32'd0);
    wait_done("divu zero", 10);
    check("divu zero hi", hi, 32'h11);
    check("divu zero lo", lo, 32'h22);

    // op 6/7 do nothing
    issue(3'd6, 32'h5555_5555, 32'd9);
    check("nop6 busy", {31'd0, busy}, 32'd0);
    check("nop6 hi", hi, 32'h11);
    issue(3'd7, 32'h5555_5555, 32'd9);
    check("nop7 lo", lo, 32'h22);

    // MTLO two cycles into a MULT is dropped
    issue(3'd0, 32'd3, 32'd4);
    @(negedge clk);
    issue(3'd5, 32'h1234_5678, 32'd0);
    check("mtlo in busy lo", lo, 32'h22);
    check("mtlo in busy busy", {31'd0, busy}, 32'd1);
    wait_done("mult late", 3);
    check("mult late hi", hi, 32'd0);
    check("mult late lo", lo, 32'd12);

    // Async reset mid-operation
    issue(3'd4, 32'h77, 32'd0);
    issue(3'd1, 32'd6, 32'd7);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) seen = 1'b1;
      end
      check("abort no result", {31'd0, seen}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
